// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port frame SRAM between three requesters. Port 0 is the
// entropy-decoder YUV writer, port 1 the colour-converter pixel reader and
// port 2 the colour-converter RGB writer. Round-robin arbitration issues at
// most one registered memory access per cycle. Read data returns to its owner
// one cycle after the access is issued.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req, we           per-port request (held until gnt) and write/read select
//   addr, wdata       packed per-port address / write data, port i at slice i
//   hold              stop issuing new grants
//   gnt               one-hot pulse: request of port i consumed this cycle
//   rvalid, rdata     one-hot read-return pulse and shared read data
//   busy              access issued or read outstanding
//   mem_en, mem_we    SRAM enable / write enable (registered)
//   mem_addr, mem_wdata  SRAM address / write data (registered)
//   mem_rdata         SRAM read data, valid one cycle after a read enable
//
// Controller states:
//   state | meaning
//   IDLE  | nothing eligible, no read in flight
//   ISSUE | a grant was made this cycle
//   DRAIN | no new grants, waiting for the last read to return
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    input  logic                  hold,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [2:0]          elig;
    logic [2:0]          rot;
    logic [1:0]          ofs;
    logic [2:0]          sum;
    logic [1:0]          win;
    logic                win_vld;
    logic [1:0]          ptr, ptr_nxt;
    logic                we_sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic                rd_pend;
    logic [1:0]          rd_owner;
    logic [1:0]          cur_owner;
    logic                read_pending;

    // Masking with the current gnt keeps a port that is still holding req in
    // its grant cycle from being issued twice.
    assign elig = req & ~gnt & {3{~hold}};

    // Rotate eligibility so that bit 0 is the port at ptr, pick the first set
    // bit, then rotate the offset back to an absolute port number.
    always_comb begin
        rot = elig;
        case (ptr)
            2'd1:    rot = {elig[0], elig[2], elig[1]};
            2'd2:    rot = {elig[1], elig[0], elig[2]};
            default: rot = elig;
        endcase
        win_vld = |rot;
        if (rot[0])      ofs = 2'd0;
        else if (rot[1]) ofs = 2'd1;
        else             ofs = 2'd2;
        sum = {1'b0, ptr} + {1'b0, ofs};
        win = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (!win_vld)
            ptr_nxt = ptr;
        else if (win == 2'd2)
            ptr_nxt = 2'd0;
        else
            ptr_nxt = win + 2'd1;
    end

    always_comb begin
        we_sel    = we[0];
        addr_sel  = addr[0 +: ADDR_W];
        wdata_sel = wdata[0 +: DATA_W];
        case (win)
            2'd1: begin
                we_sel    = we[1];
                addr_sel  = addr[ADDR_W +: ADDR_W];
                wdata_sel = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                we_sel    = we[2];
                addr_sel  = addr[2*ADDR_W +: ADDR_W];
                wdata_sel = wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // Owner of the access currently on the memory bus.
    always_comb begin
        if (gnt[2])      cur_owner = 2'd2;
        else if (gnt[1]) cur_owner = 2'd1;
        else             cur_owner = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= '0;
            ptr       <= '0;
        end else begin
            ptr     <= ptr_nxt;
            gnt     <= win_vld ? (3'b001 << win) : 3'b000;
            mem_en  <= win_vld;
            mem_we  <= win_vld & we_sel;
            // Address and data hold their last values on idle cycles.
            if (win_vld) begin
                mem_addr  <= addr_sel;
                mem_wdata <= we_sel ? wdata_sel : '0;
            end
            rd_pend  <= mem_en & ~mem_we;
            rd_owner <= cur_owner;
        end
    end

    assign rvalid = rd_pend ? (3'b001 << rd_owner) : 3'b000;
    assign rdata  = rd_pend ? mem_rdata : '0;
    assign busy   = mem_en | rd_pend;

    assign read_pending = (mem_en & ~mem_we) | rd_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|elig) state_nxt = ISSUE;
            ISSUE:   if (~|elig) state_nxt = read_pending ? DRAIN : IDLE;
            DRAIN:   state_nxt = (|elig) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port frame SRAM between three requesters:
  - port 0: entropy-decoder YUV writer
  - port 1: colour-converter pixel reader
  - port 2: colour-converter RGB writer
- Round-robin arbitration with one memory access per cycle.
- Memory-side signals are registered; read data is routed back to the owning requester.
- Sits between the decompression datapath stages and the SRAM model/macro.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 8, SRAM data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  3  per-port access request, held until gnt
we  in  3  per-port write (1) / read (0) select, valid with req
addr  in  3*ADDR_W  packed per-port addresses, port i at [i*ADDR_W +: ADDR_W]
wdata  in  3*DATA_W  packed per-port write data
hold  in  1  stop issuing new grants (quiesce)
gnt  out  3  one-hot pulse, request of port i consumed this cycle
rvalid  out  3  one-hot pulse, rdata valid for port i
rdata  out  DATA_W  read data (shared, qualified by rvalid)
busy  out  1  access issued or read outstanding
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset: gnt=0, rvalid=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_owner=0, rd_pend=0, ptr=0. Applies immediately on rst high, mid-operation included; any outstanding read is dropped and its rvalid never appears.
- Eligibility each cycle: elig = req & ~gnt & {3{~hold}}. Masking with the current gnt prevents double-issue, so one port gets at most one access every 2 cycles.
- Round-robin pointer ptr in {0,1,2}:
  - Priority order is ptr, ptr+1, ptr+2 (mod 3).
  - The first eligible port w wins.
  - On a win, ptr <= (w+1) mod 3.
  - With no winner, ptr is unchanged.
- Registered issue, cycle N arbitration -> cycle N+1 outputs:
  - gnt[w]=1
  - mem_en=1
  - mem_we=we[w]
  - mem_addr=addr[w]
  - mem_wdata=wdata[w] (mem_wdata is 0 for reads)
- With no winner at N: mem_en=0, mem_we=0, gnt=0 at N+1. mem_addr and mem_wdata hold their last values.
- Requester rules:
  - req/we/addr/wdata must stay stable from assertion until the cycle gnt is high.
  - The requester may drop req, or present a new access, from the cycle after gnt.
- Read return:
  - If the issue at N+1 is a read, set rd_pend=1 and rd_owner=w.
  - At N+2: rvalid[rd_owner]=1 and rdata=mem_rdata, combinationally passed; rdata is 0 when no rvalid.
  - Writes produce no rvalid.
- Read latency: 2 cycles from the request being sampled eligible to rvalid. Back-to-back reads pipeline, one per cycle.
- busy = mem_en | rd_pend.
- Small controller FSM:
  - States: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when elig != 0.
  - ISSUE stays while elig != 0.
  - ISSUE -> DRAIN when elig == 0 and a read is pending.
  - ISSUE -> IDLE when elig == 0 and no read is pending.
  - DRAIN -> ISSUE if elig != 0, else IDLE.
  - The FSM only sequences; its outputs follow the rules above.
- Hold:
  - Asserting hold at cycle N blocks arbitration at N.
  - An access already registered at N (outputs at N+1 from N-1) still completes.
  - busy falls once the pipeline drains.
- Simultaneous events:
  - A winner's gnt and a previous read's rvalid for a different port may coincide.
  - gnt and rvalid for the same port may also coincide.
  - Both are legal.
- Addresses and data pass through unmodified; no width conversion or wrap.

Test Plan:
- Single read: after reset, req=001 we=0 addr0=0x0010 at cycle T, SRAM[0x0010]=0x5A -> gnt=001 mem_en=1 mem_we=0 mem_addr=0x0010 at T+1; rvalid=001 rdata=0x5A at T+2; busy 1 for T+1..T+2.
- Full contention: req=111 held continuously, all reads, from reset -> gnt sequence 001,010,100,001,010,100 on consecutive cycles; rvalid follows each gnt by one cycle.
- Write: req=100 we=100 addr2=0x1234 wdata2=0xC3 -> mem_en=1 mem_we=1 mem_addr=0x1234 mem_wdata=0xC3 at T+1; SRAM[0x1234]=0xC3 afterwards; rvalid stays 000.
- Lone requester holding req: req=010 held for 6 cycles -> gnt[1] high every other cycle (T+1, T+3, T+5); ptr ends at 2.
- Hold: hold=1 with req=011 pending for 4 cycles -> gnt=000, mem_en=0; hold released at cycle H -> gnt=001 at H+1 (ptr=0), gnt=010 at H+2.
- Reset mid-read: read issued to port 1 (mem_en=1 at T+1); rst pulsed during T+1 -> rvalid stays 000 at T+2; all outputs 0; next req=100 is granted first to port 2 and ptr becomes 0.
